md_scheduler: RTL and testbench
===============================

// Module: md_scheduler
// PURPOSE
//  Sequences the multiply/divide unit and owns the HI/LO registers for the P6 pipeline.
//  Accepts mult/multu/div/divu/mthi/mtlo from E stage and holds HI/LO busy for a fixed latency.
//  Raises a D-stage stall while a HI/LO-class instruction (CalHL/MtHL/MfHL from the D-stage
//  hazard decode) would collide with the unit.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   clock, rising edge
//  reset_n   in   1   asynchronous reset, active low
//  e_start   in   1   E-stage mult/div issue strobe, one cycle per instruction
//  e_op      in   2   00 mult, 01 multu, 10 div, 11 divu; sampled with e_start
//  e_mthi    in   1   E-stage mthi strobe
//  e_mtlo    in   1   E-stage mtlo strobe
//  e_rs      in   32  operand A / mthi-mtlo data
//  e_rt      in   32  operand B
//  d_cal_hl  in   1   D-stage instruction is mult/multu/div/divu
//  d_mt_hl   in   1   D-stage instruction is mthi/mtlo
//  d_mf_hl   in   1   D-stage instruction is mfhi/mflo
//  busy      out  1   operation in flight
//  stall     out  1   freeze F/D, bubble into E
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE, counter 0, busy=0, hi=0, lo=0, pending result cleared.
//    Reset mid-operation discards the pending result; HI/LO read 0 after release.
//  - FSM IDLE/BUSY. IDLE --e_start--> BUSY, counter loaded with MULT_CYCLES or DIV_CYCLES per e_op[1].
//    BUSY: counter decrements each edge; on the edge where counter==1, HI/LO <= pending result,
//    busy falls, state returns to IDLE. busy=1 from the cycle after e_start for exactly N cycles.
//  - Result is computed and latched into a pending register at the e_start edge (operands are not
//    required stable afterward). HI/LO stay at their old values until the completion edge.
//  - mult: {hi,lo} = signed 64-bit product; multu: unsigned product.
//  - div/divu: lo = quotient, hi = remainder; signed remainder takes the sign of the dividend.
//  - Divide by zero (e_rt==0): hi = e_rs, lo = 32'hFFFF_FFFF; normal latency.
//  - Signed overflow 32'h8000_0000 / -1: lo = 32'h8000_0000, hi = 0.
//  - e_mthi/e_mtlo in IDLE: hi or lo <= e_rs at the next edge; busy unaffected.
//  - e_start, e_mthi or e_mtlo while BUSY: ignored, no state change (the stall makes this illegal).
//  - e_start with e_mthi/e_mtlo in the same cycle: e_start wins; move ignored.
//  - stall = (busy | e_start) & (d_cal_hl | d_mt_hl | d_mf_hl), purely combinational.
//    It drops in the cycle busy falls, so a waiting mfhi reads the new HI in that cycle.
//  - hi/lo are registered outputs; there is no bypass of a same-cycle mthi to the read port.
// TESTING
//  1 reset: drive reset_n=0 mid-BUSY -> busy=0, hi=lo=0 immediately; no late write after release.
//  2 mult e_rs=-3, e_rt=7 -> busy high 5 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
//  3 divu 100/7 with d_mf_hl=1 held -> stall=1 for e_start cycle + 10 busy cycles; then lo=14, hi=2, stall=0.
//  4 div -7/2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; div 5/0 -> hi=5, lo=32'hFFFF_FFFF.
//  5 mthi 32'h1234 in IDLE -> hi=32'h1234 next cycle; mtlo while BUSY -> lo unchanged.
//  6 e_start during BUSY with different operands -> ignored; first result and latency preserved.

Source files
------------

// File: rtl/md_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : md_scheduler
// Description : Multiply/divide sequencer owning HI/LO; computes the result at
//               issue, holds it for a fixed latency, and stalls D on HI/LO use.
// Revision    : 1.0 - initial release
// ============================================================================
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        e_start,
    input  logic [1:0]  e_op,
    input  logic        e_mthi,
    input  logic        e_mtlo,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_cal_hl,
    input  logic        d_mt_hl,
    input  logic        d_mf_hl,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam logic [1:0] c_OP_MULT  = 2'b00;
    localparam logic [1:0] c_OP_MULTU = 2'b01;
    localparam logic [1:0] c_OP_DIV   = 2'b10;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_last;
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [31:0]        w_sdiv_b;
    logic [31:0]        w_udiv_b;
    logic [31:0]        w_sq;
    logic [31:0]        w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    assign w_last = (r_cnt == c_CNT_W'(1));

    // ------------------------------------------------------------------------
    // Result datapath, evaluated combinationally from the E-stage operands
    // ------------------------------------------------------------------------
    assign w_prod_s = $signed({{32{e_rs[31]}}, e_rs}) * $signed({{32{e_rt[31]}}, e_rt});
    assign w_prod_u = {32'd0, e_rs} * {32'd0, e_rt};

    assign w_div_zero = (e_rt == 32'd0);
    assign w_div_ovf  = (e_rs == 32'h8000_0000) && (e_rt == 32'hFFFF_FFFF);

    // Dividing by one reproduces the mandated overflow result and keeps the
    // divider away from the undefined zero / overflow operand pairs.
    assign w_sdiv_b = (w_div_zero || w_div_ovf) ? 32'd1 : e_rt;
    assign w_udiv_b = w_div_zero ? 32'd1 : e_rt;

    assign w_sq = $signed(e_rs) / $signed(w_sdiv_b);
    assign w_sr = $signed(e_rs) % $signed(w_sdiv_b);
    assign w_uq = e_rs / w_udiv_b;
    assign w_ur = e_rs % w_udiv_b;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (e_op)
            c_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            c_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            c_OP_DIV: begin
                if (w_div_zero) begin
                    w_res_hi = e_rs;
                    w_res_lo = 32'hFFFF_FFFF;
                end else begin
                    w_res_hi = w_sr;
                    w_res_lo = w_sq;
                end
            end
            default: begin
                if (w_div_zero) begin
                    w_res_hi = e_rs;
                    w_res_lo = 32'hFFFF_FFFF;
                end else begin
                    w_res_hi = w_ur;
                    w_res_lo = w_uq;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (e_start) w_next_state = c_BUSY;
            c_BUSY:  if (w_last)  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (r_state == c_BUSY) begin
            busy = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Counter, pending result and architectural HI/LO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else if (r_state == c_IDLE) begin
            if (e_start) begin
                r_cnt     <= e_op[1] ? c_CNT_W'(DIV_CYCLES) : c_CNT_W'(MULT_CYCLES);
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
            end else begin
                if (e_mthi) r_hi <= e_rs;
                if (e_mtlo) r_lo <= e_rs;
            end
        end else begin
            // Issue and moves arriving while busy are dropped; the stall forbids them.
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_last) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = (busy | e_start) & (d_cal_hl | d_mt_hl | d_mf_hl);

endmodule
`default_nettype wire

// File: tb/tb_md_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_scheduler
// Description : Directed self-checking bench for md_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_scheduler;

    logic        clk;
    logic        reset_n;
    logic        e_start;
    logic [1:0]  e_op;
    logic        e_mthi;
    logic        e_mtlo;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_cal_hl;
    logic        d_mt_hl;
    logic        d_mf_hl;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    md_scheduler #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .e_start  (e_start),
        .e_op     (e_op),
        .e_mthi   (e_mthi),
        .e_mtlo   (e_mtlo),
        .e_rs     (e_rs),
        .e_rt     (e_rt),
        .d_cal_hl (d_cal_hl),
        .d_mt_hl  (d_mt_hl),
        .d_mf_hl  (d_mf_hl),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op: called at posedge+1, returns at the following posedge+1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        e_start = 1'b1;
        e_op    = op;
        e_rs    = a;
        e_rt    = b;
        @(posedge clk);
        #1;
        e_start = 1'b0;
        e_rs    = 32'hDEAD_BEEF;
        e_rt    = 32'hCAFE_F00D;
    endtask

    // Counts busy/stall cycles at negedges; returns at the first idle negedge.
    task automatic wait_done(output int n_busy, output int n_stall);
        n_busy  = 0;
        n_stall = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (!busy) break;
            n_busy++;
        end
    endtask

    task automatic test_reset();
        int nb;
        int ns;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        e_mthi = 1'b1; e_rs = 32'h55;
        @(posedge clk);
        #1;
        e_mthi = 1'b0;
        checks++; if (hi !== 32'h55) begin errors++; $display("FAIL pre_reset_mthi got %h want 00000055", hi); end
        issue(2'b00, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midop_reset_busy got %0b want 0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midop_reset_hilo got %h_%h want 0_0", hi, lo); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b want 0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL no_late_write got %h_%h want 0_0", hi, lo); end
        wait_done(nb, ns);
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult();
        int nb;
        int ns;
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || lo !== 32'd0) begin errors++; $display("FAIL mult_hold got busy=%0b lo=%h want 1 00000000", busy, lo); end
        wait_done(nb, ns);
        checks++; if (nb !== 4) begin errors++; $display("FAIL mult_latency got %0d want 4 more busy cycles", nb); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_result got %h_%h want ffffffff_ffffffeb", hi, lo); end
        @(posedge clk);
        #1;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(nb, ns);
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_result got %h_%h want fffffffe_00000001", hi, lo); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_divu_stall();
        int nb;
        int ns;
        int n_start_stall;
        d_mf_hl = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %0b want 0", stall); end
        e_start = 1'b1; e_op = 2'b11; e_rs = 32'd100; e_rt = 32'd7;
        #1;
        n_start_stall = stall ? 1 : 0;
        @(posedge clk);
        #1;
        e_start = 1'b0; e_rs = 32'd0; e_rt = 32'd0;
        wait_done(nb, ns);
        checks++; if (nb !== 10) begin errors++; $display("FAIL divu_latency got %0d want 10", nb); end
        checks++; if (n_start_stall + ns !== 11) begin errors++; $display("FAIL divu_stall_cycles got %0d want 11", n_start_stall + ns); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_drop got %0b want 0", stall); end
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu_result got hi=%0d lo=%0d want hi=2 lo=14", hi, lo); end
        d_mf_hl = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_div();
        int nb;
        int ns;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(nb, ns);
        checks++; if (nb !== 10) begin errors++; $display("FAIL div_latency got %0d want 10", nb); end
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo); end
        @(posedge clk);
        #1;
        issue(2'b10, 32'd5, 32'd0);
        wait_done(nb, ns);
        checks++; if (nb !== 10) begin errors++; $display("FAIL div0_latency got %0d want 10", nb); end
        checks++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero got %h_%h want 00000005_ffffffff", hi, lo); end
        @(posedge clk);
        #1;
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(nb, ns);
        checks++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow got %h_%h want 00000000_80000000", hi, lo); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_move();
        int nb;
        int ns;
        e_mthi = 1'b1; e_rs = 32'h1234;
        @(negedge clk);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mthi_no_bypass got %h want 00000000", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0b want 0", busy); end
        @(posedge clk);
        #1;
        e_mthi = 1'b0;
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h want 00001234", hi); end
        e_mtlo = 1'b1; e_rs = 32'hABCD;
        @(posedge clk);
        #1;
        e_mtlo = 1'b0;
        checks++; if (lo !== 32'hABCD || hi !== 32'h1234) begin errors++; $display("FAIL mtlo got %h_%h want 00001234_0000abcd", hi, lo); end
        issue(2'b00, 32'd2, 32'd3);
        e_mtlo = 1'b1; e_rs = 32'hDEAD;
        @(posedge clk);
        #1;
        e_mtlo = 1'b0;
        checks++; if (lo !== 32'hABCD) begin errors++; $display("FAIL mtlo_while_busy got %h want 0000abcd", lo); end
        wait_done(nb, ns);
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL mult_after_mtlo got %h_%h want 00000000_00000006", hi, lo); end
        @(posedge clk);
        #1;
        e_mthi = 1'b1;
        issue(2'b01, 32'd1, 32'd1);
        e_mthi = 1'b0;
        @(negedge clk);
        checks++; if (hi !== 32'd0 || busy !== 1'b1) begin errors++; $display("FAIL start_beats_mthi got hi=%h busy=%0b want 00000000 1", hi, busy); end
        wait_done(nb, ns);
        checks++; if (hi !== 32'd0 || lo !== 32'd1) begin errors++; $display("FAIL multu_one got %h_%h want 00000000_00000001", hi, lo); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int nb;
        int ns;
        issue(2'b00, 32'd6, 32'd7);
        issue(2'b11, 32'd100, 32'd7);
        wait_done(nb, ns);
        checks++; if (nb !== 4) begin errors++; $display("FAIL ignored_start_latency got %0d want 4", nb); end
        checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL ignored_start_result got hi=%0d lo=%0d want hi=0 lo=42", hi, lo); end
        @(posedge clk);
        #1;
        issue(2'b11, 32'd50, 32'd8);
        wait_done(nb, ns);
        checks++; if (nb !== 10 || hi !== 32'd2 || lo !== 32'd6) begin errors++; $display("FAIL followup_divu got n=%0d hi=%0d lo=%0d want 10 2 6", nb, hi, lo); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        e_start  = 1'b0;
        e_op     = 2'b00;
        e_mthi   = 1'b0;
        e_mtlo   = 1'b0;
        e_rs     = 32'd0;
        e_rt     = 32'd0;
        d_cal_hl = 1'b0;
        d_mt_hl  = 1'b0;
        d_mf_hl  = 1'b0;
        test_reset();
        test_mult();
        test_divu_stall();
        test_div();
        test_move();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
